// File: rtl/coin_input_ctrl_if.sv
// coin_input_ctrl_if: coin keys, vend/cancel requests and the credit/status outputs of the coin front end
interface coin_input_ctrl_if #(
    parameter int CREDIT_W = 8
);
    logic [2:0]          coin_key_n;
    logic                coin_cancel;
    logic                vend_req;
    logic [CREDIT_W-1:0] vend_price;
    logic [CREDIT_W-1:0] coin_credit;
    logic                coin_strobe_n;
    logic                coin_reject;
    logic                vend_ok;
    logic                vend_deny;
    logic                refund_valid;
    logic [CREDIT_W-1:0] refund_amt;
    modport master (
        output coin_key_n, coin_cancel, vend_req, vend_price,
        input  coin_credit, coin_strobe_n, coin_reject, vend_ok, vend_deny, refund_valid, refund_amt
    );
    modport slave (
        input  coin_key_n, coin_cancel, vend_req, vend_price,
        output coin_credit, coin_strobe_n, coin_reject, vend_ok, vend_deny, refund_valid, refund_amt
    );
endinterface

// File: rtl/coin_input_ctrl.sv
// coin_input_ctrl: debounces coin keys, accumulates saturating credit, services vend and cancel
module coin_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CREDIT_W        = 8,
    parameter int CREDIT_MAX      = 99,
    parameter int COIN0_VAL       = 1,
    parameter int COIN1_VAL       = 5,
    parameter int COIN2_VAL       = 10
) (
    input logic             coin_clk,
    input logic             coin_rst,
    coin_input_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] COMMIT       = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;
    logic [2:0]          sync1, sync2, k, hot;
    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic                one_hot, afford, vend_go, commit, coin_ok;
    logic [CREDIT_W-1:0] base, credit_nx;
    logic [CREDIT_W:0]   val, sum;
    assign k = ~sync2;
    assign one_hot = (k != 3'd0) && ((k & (k - 3'd1)) == 3'd0);
    assign val = hot[2] ? (CREDIT_W+1)'(COIN2_VAL) : hot[1] ? (CREDIT_W+1)'(COIN1_VAL) : (CREDIT_W+1)'(COIN0_VAL);
    // cancel wipes credit and blocks vend; vend is judged on the pre-cycle credit
    assign afford = bus.coin_credit >= bus.vend_price;
    assign vend_go = bus.vend_req && !bus.coin_cancel && afford;
    assign base = bus.coin_cancel ? '0 : vend_go ? bus.coin_credit - bus.vend_price : bus.coin_credit;
    // one extra bit keeps the limit compare free of wraparound
    assign sum = {1'b0, base} + val;
    assign commit = state == COMMIT;
    assign coin_ok = commit && !bus.coin_cancel && sum <= (CREDIT_W+1)'(CREDIT_MAX);
    assign credit_nx = coin_ok ? sum[CREDIT_W-1:0] : base;
    always_ff @(posedge coin_clk) begin
        if (coin_rst) begin
            sync1             <= '1;
            sync2             <= '1;
            state             <= IDLE;
            cnt               <= '0;
            hot               <= '0;
            bus.coin_credit   <= '0;
            bus.coin_strobe_n <= 1'b1;
            bus.coin_reject   <= 1'b0;
            bus.vend_ok       <= 1'b0;
            bus.vend_deny     <= 1'b0;
            bus.refund_valid  <= 1'b0;
            bus.refund_amt    <= '0;
        end else begin
            sync1             <= bus.coin_key_n;
            sync2             <= sync1;
            bus.coin_credit   <= credit_nx;
            bus.coin_strobe_n <= !coin_ok;
            bus.coin_reject   <= commit && !coin_ok;
            bus.vend_ok       <= vend_go;
            bus.vend_deny     <= bus.vend_req && !bus.coin_cancel && !afford;
            bus.refund_valid  <= bus.coin_cancel && bus.coin_credit != '0;
            bus.refund_amt    <= bus.coin_cancel ? bus.coin_credit : '0;
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        hot   <= k;
                        cnt   <= CW'(1);
                        state <= DEBOUNCE;
                    end else if (k != 3'd0) begin
                        cnt   <= '0;
                        state <= WAIT_RELEASE;
                    end
                end
                DEBOUNCE: begin
                    if (k != hot) state <= IDLE;
                    else begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) state <= COMMIT;
                    end
                end
                COMMIT: begin
                    cnt   <= '0;
                    state <= WAIT_RELEASE;
                end
                default: begin
                    if (k != 3'd0) cnt <= '0;
                    else if (cnt != '0) state <= IDLE;
                    else cnt <= CW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coin_input_ctrl.sv
// tb_coin_input_ctrl: directed coin, vend, cancel and reset scenarios with hand-computed expectations
module tb_coin_input_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int st, fi, rj, so, sa, tot;
    coin_input_ctrl_if #(.CREDIT_W(8)) bus ();
    coin_input_ctrl #(
        .DEBOUNCE_CYCLES(20), .CREDIT_W(8), .CREDIT_MAX(99),
        .COIN0_VAL(1), .COIN1_VAL(5), .COIN2_VAL(10)
    ) dut (
        .coin_clk(clk),
        .coin_rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // act 1 = vend, act 2 = cancel, driven so it lands on the COMMIT edge (edge 23)
    task automatic press(input logic [2:0] mask, input int hold, input int act, input int price,
                         output int strobes, output int first, output int rejects,
                         output int side_ok, output int side_amt);
        strobes = 0; first = 0; rejects = 0; side_ok = 0; side_amt = 0;
        @(negedge clk);
        bus.coin_key_n = ~mask;
        for (int i = 1; i <= hold + 6; i++) begin
            @(negedge clk);
            if (!bus.coin_strobe_n) begin
                strobes++;
                if (first == 0) first = i;
            end
            if (bus.coin_reject) rejects++;
            if (i == 23) begin
                side_ok = int'(bus.vend_ok);
                side_amt = int'(bus.refund_amt);
            end
            if (i == hold) bus.coin_key_n = 3'b111;
            bus.vend_req = act == 1 && i == 22;
            bus.coin_cancel = act == 2 && i == 22;
            bus.vend_price = 8'(price);
        end
    endtask
    task automatic add(input int idx, input int times, output int strobes);
        int s, f, r, o, a;
        strobes = 0;
        for (int j = 0; j < times; j++) begin
            press(3'(1 << idx), 25, 0, 0, s, f, r, o, a);
            strobes += s;
        end
    endtask
    task automatic vend(input int price);
        @(negedge clk);
        bus.vend_req = 1'b1;
        bus.vend_price = 8'(price);
        @(negedge clk);
        bus.vend_req = 1'b0;
    endtask
    task automatic cancel();
        @(negedge clk);
        bus.coin_cancel = 1'b1;
        @(negedge clk);
        bus.coin_cancel = 1'b0;
    endtask
    initial begin
        bus.coin_key_n = 3'b111;
        bus.coin_cancel = 1'b0;
        bus.vend_req = 1'b0;
        bus.vend_price = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_credit", int'(bus.coin_credit), 0);
        check("rst_strobe_n", int'(bus.coin_strobe_n), 1);
        check("rst_reject", int'(bus.coin_reject), 0);
        check("rst_refund", int'(bus.refund_amt), 0);
        rst = 1'b0;
        press(3'b001, 10, 0, 0, st, fi, rj, so, sa);
        check("glitch_strobes", st, 0);
        check("glitch_credit", int'(bus.coin_credit), 0);
        press(3'b101, 40, 0, 0, st, fi, rj, so, sa);
        check("multi_strobes", st, 0);
        check("multi_rejects", rj, 0);
        check("multi_credit", int'(bus.coin_credit), 0);
        press(3'b010, 40, 0, 0, st, fi, rj, so, sa);
        check("key1_strobes", st, 1);
        check("key1_latency", fi, 23);
        check("key1_credit", int'(bus.coin_credit), 5);
        add(2, 9, tot);
        check("fill_credit", int'(bus.coin_credit), 95);
        press(3'b100, 25, 0, 0, st, fi, rj, so, sa);
        check("over_rejects", rj, 1);
        check("over_strobes", st, 0);
        check("over_credit", int'(bus.coin_credit), 95);
        add(0, 4, tot);
        check("max_strobes", tot, 4);
        check("max_credit", int'(bus.coin_credit), 99);
        cancel();
        check("cancel_valid", int'(bus.refund_valid), 1);
        check("cancel_amt", int'(bus.refund_amt), 99);
        check("cancel_credit", int'(bus.coin_credit), 0);
        cancel();
        check("cancel0_valid", int'(bus.refund_valid), 0);
        check("cancel0_amt", int'(bus.refund_amt), 0);
        add(2, 1, tot);
        add(0, 2, tot);
        check("twelve_credit", int'(bus.coin_credit), 12);
        vend(15);
        check("deny_flag", int'(bus.vend_deny), 1);
        check("deny_ok", int'(bus.vend_ok), 0);
        check("deny_credit", int'(bus.coin_credit), 12);
        vend(12);
        check("exact_ok", int'(bus.vend_ok), 1);
        check("exact_credit", int'(bus.coin_credit), 0);
        vend(0);
        check("free_ok", int'(bus.vend_ok), 1);
        check("free_deny", int'(bus.vend_deny), 0);
        add(2, 3, tot);
        check("thirty_credit", int'(bus.coin_credit), 30);
        press(3'b100, 25, 1, 10, st, fi, rj, so, sa);
        check("vc_vend_ok", so, 1);
        check("vc_strobes", st, 1);
        check("vc_credit", int'(bus.coin_credit), 30);
        press(3'b100, 25, 2, 0, st, fi, rj, so, sa);
        check("cc_refund_amt", sa, 30);
        check("cc_rejects", rj, 1);
        check("cc_strobes", st, 0);
        check("cc_credit", int'(bus.coin_credit), 0);
        add(1, 1, tot);
        check("pre_rst_credit", int'(bus.coin_credit), 5);
        st = 0; fi = 0;
        @(negedge clk);
        bus.coin_key_n = 3'b110;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 9) rst = 1'b1;
            if (!bus.coin_strobe_n) st++;
        end
        check("midrst_strobes", st, 0);
        check("midrst_credit", int'(bus.coin_credit), 0);
        rst = 1'b0;
        st = 0;
        for (int i = 1; i <= 46; i++) begin
            @(negedge clk);
            if (!bus.coin_strobe_n) begin
                st++;
                if (fi == 0) fi = i;
            end
            if (i == 40) bus.coin_key_n = 3'b111;
        end
        check("postrst_strobes", st, 1);
        check("postrst_latency", fi, 23);
        check("postrst_credit", int'(bus.coin_credit), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
